// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_loader_pkg
// Brief  : Shared types and helpers for the UART-to-memory loader.
// Rev    : 1.0  initial release
// ============================================================================
package uart_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        B_IDLE  = 1'b0,
        B_WRITE = 1'b1
    } bus_state_t;

    localparam logic [3:0] WSTRB_FULL = 4'b1111;

    // Byte enables for a partial word holding n low bytes.
    function automatic logic [3:0] partial_strb(input logic [1:0] n);
        case (n)
            2'd1:    partial_strb = 4'b0001;
            2'd2:    partial_strb = 4'b0011;
            2'd3:    partial_strb = 4'b0111;
            default: partial_strb = WSTRB_FULL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_core
// Brief  : 8N1 UART receiver with a 2-flop input synchronizer.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);
    import uart_loader_pkg::*;

    localparam int c_HALF = CLKS_PER_BIT / 2;
    localparam int c_CW   = $clog2(CLKS_PER_BIT);

    logic            r_sync1;
    logic            r_sync2;
    logic [c_CW-1:0] r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    rx_state_t       r_state;
    rx_state_t       w_next;
    logic            w_half_tick;
    logic            w_bit_tick;

    assign w_half_tick = (r_clk_cnt == c_CW'(c_HALF - 1));
    assign w_bit_tick  = (r_clk_cnt == c_CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= RX_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (!r_sync2) w_next = RX_START;
            RX_START: if (w_half_tick) w_next = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_tick && (r_bit_idx == 3'd7)) w_next = RX_STOP;
            RX_STOP:  if (w_bit_tick) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    // Bit timer restarts at mid-start so later samples land mid-bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if ((r_state == RX_IDLE) || ((r_state == RX_START) && w_half_tick) || w_bit_tick)
                r_clk_cnt <= '0;
            else
                r_clk_cnt <= r_clk_cnt + c_CW'(1);
            if (r_state == RX_IDLE)
                r_bit_idx <= '0;
            else if ((r_state == RX_DATA) && w_bit_tick) begin
                r_shift   <= {r_sync2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        o_byte_valid = (r_state == RX_STOP) && w_bit_tick && r_sync2;
        o_frame_err  = (r_state == RX_STOP) && w_bit_tick && !r_sync2;
    end

    assign o_byte = r_shift;

endmodule
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module : uart_mem_loader
// Brief  : Packs UART bytes into 32-bit words and writes them over a
//          valid/ready bus. Optional checksum output: UART_LOADER_CKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
module uart_mem_loader
    import uart_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT   = 217,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MEM_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count,
    output logic        frame_err,
    output logic        overrun
`ifdef UART_LOADER_CKSUM_EN
    ,
    output logic [7:0]  cksum
`endif
);

    localparam logic [31:0]     c_LAST_ADDR = BASE_ADDR + 32'(4 * (MEM_WORDS - 1));
    localparam int              c_TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]      w_rx_byte;
    logic            w_rx_valid;
    logic            w_rx_ferr;
    logic            r_busy;
    logic            r_flushing;
    logic            r_done;
    logic            r_held_valid;
    logic [7:0]      r_held_byte;
    logic [1:0]      r_byte_cnt;
    logic [23:0]     r_word;
    logic [c_TW-1:0] r_to_cnt;
    logic [15:0]     r_word_count;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_frame_err;
    logic            r_overrun;
    bus_state_t      r_bus_state;
    bus_state_t      w_bus_next;
    logic            w_in_valid;
    logic [7:0]      w_in_byte;
    logic            w_timeout;
    logic            w_ack;
    logic            w_finish;
    logic            w_handoff;
    logic [31:0]     w_ho_data;
    logic [3:0]      w_ho_strb;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .i_rx         (uart_rx),
        .o_byte       (w_rx_byte),
        .o_byte_valid (w_rx_valid),
        .o_frame_err  (w_rx_ferr)
    );

    // A byte landing during a flush waits in the hold slot for the next burst.
    assign w_in_valid = !r_flushing && (r_held_valid || w_rx_valid);
    assign w_in_byte  = r_held_valid ? r_held_byte : w_rx_byte;
    assign w_timeout  = r_busy && !r_flushing && !w_in_valid &&
                        (r_to_cnt == c_TO_LAST) && (r_bus_state == B_IDLE);
    assign w_ack      = (r_bus_state == B_WRITE) && mem_ready;
    assign w_finish   = (w_timeout && (r_byte_cnt == 2'd0)) || (r_flushing && w_ack);

    always_comb begin
        w_handoff = 1'b0;
        w_ho_data = '0;
        w_ho_strb = '0;
        if (w_in_valid && (r_byte_cnt == 2'd3)) begin
            w_handoff = 1'b1;
            w_ho_data = {w_in_byte, r_word};
            w_ho_strb = WSTRB_FULL;
        end else if (w_timeout && (r_byte_cnt != 2'd0)) begin
            w_handoff = 1'b1;
            w_ho_data = {8'h00, r_word};
            w_ho_strb = partial_strb(r_byte_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy       <= 1'b0;
            r_flushing   <= 1'b0;
            r_done       <= 1'b0;
            r_held_valid <= 1'b0;
            r_held_byte  <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_to_cnt     <= '0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_rx_valid && r_flushing) begin
                r_held_valid <= 1'b1;
                r_held_byte  <= w_rx_byte;
            end else if (w_in_valid) begin
                r_held_valid <= 1'b0;
            end
            if (w_in_valid) begin
                r_busy   <= 1'b1;
                r_to_cnt <= '0;
                case (r_byte_cnt)
                    2'd0:    r_word[7:0]   <= w_in_byte;
                    2'd1:    r_word[15:8]  <= w_in_byte;
                    2'd2:    r_word[23:16] <= w_in_byte;
                    default: r_word        <= '0;
                endcase
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end else if (w_timeout && (r_byte_cnt != 2'd0)) begin
                r_flushing <= 1'b1;
                r_byte_cnt <= '0;
                r_word     <= '0;
            end else if (r_busy && !r_flushing && (r_to_cnt != c_TO_LAST)) begin
                r_to_cnt <= r_to_cnt + c_TW'(1);
            end
            if (w_finish) begin
                r_busy     <= 1'b0;
                r_flushing <= 1'b0;
            end
            if (w_rx_ferr)
                r_frame_err <= 1'b1;
            if (w_handoff && (r_bus_state == B_WRITE))
                r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_bus_state <= B_IDLE;
        else       r_bus_state <= w_bus_next;
    end

    always_comb begin
        w_bus_next = r_bus_state;
        case (r_bus_state)
            B_IDLE:  if (w_handoff) w_bus_next = B_WRITE;
            B_WRITE: if (mem_ready) w_bus_next = B_IDLE;
            default: w_bus_next = B_IDLE;
        endcase
    end

    always_comb begin
        mem_valid = (r_bus_state == B_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= BASE_ADDR;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_word_count <= '0;
        end else begin
            if ((r_bus_state == B_IDLE) && w_handoff) begin
                r_wdata <= w_ho_data;
                r_wstrb <= w_ho_strb;
            end
            if (w_finish)
                r_addr <= BASE_ADDR;
            else if (w_ack)
                r_addr <= (r_addr == c_LAST_ADDR) ? BASE_ADDR : r_addr + 32'd4;
            if (w_in_valid && !r_busy)
                r_word_count <= '0;
            else if (w_ack && (r_word_count != 16'hFFFF))
                r_word_count <= r_word_count + 16'd1;
        end
    end

`ifdef UART_LOADER_CKSUM_EN
    logic [7:0] r_cksum;
    always_ff @(posedge clk) begin
        if (reset)
            r_cksum <= '0;
        else if (w_in_valid)
            r_cksum <= r_busy ? (r_cksum + w_in_byte) : w_in_byte;
    end
    assign cksum = r_cksum;
`endif

    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_wstrb  = r_wstrb;
    assign busy       = r_busy;
    assign done       = r_done;
    assign word_count = r_word_count;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_mem_loader
// Brief  : Directed and random bursts for uart_mem_loader, two instances
//          (1024-word and 2-word windows) sharing one serial line.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_mem_loader;

    localparam int c_CPB = 8;
    localparam int c_TO  = 200;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        uart_rx = 1'b1;
    logic        mem_valid  [2];
    logic        mem_ready  [2] = '{1'b0, 1'b0};
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic [3:0]  mem_wstrb  [2];
    logic        busy       [2];
    logic        done       [2];
    logic [15:0] word_count [2];
    logic        frame_err  [2];
    logic        overrun    [2];
    logic        ready_en   [2] = '{1'b1, 1'b1};
    int          rdy_cnt    [2] = '{0, 0};
    wr_t         log0[$];
    wr_t         log1[$];
    logic [7:0]  exp_bytes[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    uart_mem_loader #(.CLKS_PER_BIT(c_CPB), .BASE_ADDR(32'h0), .MEM_WORDS(1024),
                      .TIMEOUT_CYCLES(c_TO)) dut0 (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .busy(busy[0]),
        .done(done[0]), .word_count(word_count[0]), .frame_err(frame_err[0]),
        .overrun(overrun[0])
    );

    uart_mem_loader #(.CLKS_PER_BIT(c_CPB), .BASE_ADDR(32'h0), .MEM_WORDS(2),
                      .TIMEOUT_CYCLES(c_TO)) dut1 (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .busy(busy[1]),
        .done(done[1]), .word_count(word_count[1]), .frame_err(frame_err[1]),
        .overrun(overrun[1])
    );

    // Slave: ready 2 cycles after valid; a write is logged when ready is raised.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!mem_valid[k] || mem_ready[k]) begin
                mem_ready[k] = 1'b0;
                rdy_cnt[k]   = 0;
            end else begin
                rdy_cnt[k]++;
                if (rdy_cnt[k] >= 2 && ready_en[k]) begin
                    mem_ready[k] = 1'b1;
                    if (k == 0) log0.push_back('{mem_addr[k], mem_wdata[k], mem_wstrb[k]});
                    else        log1.push_back('{mem_addr[k], mem_wdata[k], mem_wstrb[k]});
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        logic [9:0] frame;
        frame = {~bad_stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (c_CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (2 * c_CPB) @(negedge clk);
    endtask

    task automatic send_all();
        foreach (exp_bytes[i]) send_byte(exp_bytes[i], 1'b0);
    endtask

    task automatic rand_bytes(input int n);
        exp_bytes.delete();
        for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom));
    endtask

    task automatic wait_done(input int k, input string tag);
        int n;
        n = 0;
        while (done[k] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done[k], 1);
        check({tag, "_busy_after"}, busy[k], 0);
        check({tag, "_addr_rewind"}, mem_addr[k], 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done[k], 0);
    endtask

    // Reference: bytes in arrival order, packed little-endian, 4 per word.
    task automatic check_writes(input int k, input string tag);
        wr_t exp_q[$];
        wr_t got[$];
        wr_t e;
        int  mw;
        int  nw;
        mw = (k == 0) ? 1024 : 2;
        nw = (exp_bytes.size() + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            e.addr = 32'(4 * (w % mw));
            e.data = '0;
            e.strb = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * w + j < exp_bytes.size()) begin
                    e.data[8*j +: 8] = exp_bytes[4*w+j];
                    e.strb[j]        = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        if (k == 0) got = log0;
        else        got = log1;
        check({tag, "_nwrites"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), got[i].addr, exp_q[i].addr);
            check($sformatf("%s_data%0d", tag, i), got[i].data, exp_q[i].data);
            check($sformatf("%s_strb%0d", tag, i), got[i].strb, exp_q[i].strb);
        end
        check({tag, "_word_count"}, word_count[k], nw);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, mem_valid[0], 0);
        check({tag, "_addr"}, mem_addr[0], 0);
        check({tag, "_wdata"}, mem_wdata[0], 0);
        check({tag, "_wstrb"}, mem_wstrb[0], 0);
        check({tag, "_busy"}, busy[0], 0);
        check({tag, "_done"}, done[0], 0);
        check({tag, "_wcount"}, word_count[0], 0);
        check({tag, "_ferr"}, frame_err[0], 0);
        check({tag, "_ovr"}, overrun[0], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b4 [4];
        int n;

        repeat (3) @(negedge clk);
        check_reset_state("RST");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single full word
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        log0.delete(); log1.delete();
        send_all();
        check("A_busy", busy[0], 1);
        wait_done(0, "A");
        check_writes(0, "A");

        // Two full words plus a 2-byte tail
        exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA, 8'hBB};
        log0.delete(); log1.delete();
        send_all();
        wait_done(0, "B");
        check_writes(0, "B");

        // Bad stop bit on the second byte
        for (int i = 0; i < 4; i++) b4[i] = 8'($urandom);
        log0.delete(); log1.delete();
        for (int i = 0; i < 4; i++) send_byte(b4[i], i == 1);
        check("C_frame_err", frame_err[0], 1);
        exp_bytes = '{b4[0], b4[2], b4[3]};
        wait_done(0, "C");
        check_writes(0, "C");

        // Slave stalled across two words: second word dropped
        ready_en[0] = 1'b0;
        rand_bytes(8);
        log0.delete(); log1.delete();
        send_all();
        check("D_overrun", overrun[0], 1);
        check("D_valid_held", mem_valid[0], 1);
        check("D_addr_held", mem_addr[0], 0);
        check("D_wdata_held", mem_wdata[0], {exp_bytes[3], exp_bytes[2], exp_bytes[1], exp_bytes[0]});
        exp_bytes = exp_bytes[0:3];
        ready_en[0] = 1'b1;
        wait_done(0, "D");
        check_writes(0, "D");

        // Address wrap in the 2-word window
        rand_bytes(12);
        log0.delete(); log1.delete();
        send_all();
        wait_done(1, "E");
        check_writes(1, "E");

        // Random bursts
        for (int r = 0; r < 3; r++) begin
            rand_bytes($urandom_range(1, 11));
            log0.delete(); log1.delete();
            send_all();
            wait_done(0, $sformatf("F%0d", r));
            check_writes(0, $sformatf("F%0d", r));
        end

        // Reset while a write is pending
        ready_en[0] = 1'b0;
        rand_bytes(4);
        send_all();
        n = 0;
        while (mem_valid[0] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("G_valid_before", mem_valid[0], 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("G");
        reset = 1'b0;
        ready_en[0] = 1'b1;
        repeat (4) @(negedge clk);
        rand_bytes(4);
        log0.delete(); log1.delete();
        send_all();
        wait_done(0, "H");
        check_writes(0, "H");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
